// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared mixer types, defaults and the averaging shift helper
package synth_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_NUM_VOICES = 4;

    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_OUT
    } mix_state_t;

    // Level normalisation: fewer active voices need less attenuation
    function automatic logic [1:0] avg_shift(input logic [DEF_NUM_VOICES-1:0] en);
        int n;
        n = $countones(en);
        if (n <= 1)
            return 2'd0;
        else if (n == 2)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/sat_shift.sv
// rtl/sat_shift.sv - arithmetic right shift plus saturation from ACC_W down to DATA_W
module sat_shift
    import synth_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DATA_W + 2
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [1:0]        shift,
    output logic        [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]      shifted;
    logic        [ACC_W-DATA_W:0] head;

    // The value fits when every bit above the output sign bit matches it
    always_comb begin
        shifted = acc >>> shift;
        head    = shifted[ACC_W-1:DATA_W-1];
        if ((&head) || (~|head))
            result = shifted[DATA_W-1:0];
        else if (shifted[ACC_W-1])
            result = {1'b1, {(DATA_W-1){1'b0}}};
        else
            result = {1'b0, {(DATA_W-1){1'b1}}};
    end

endmodule

// File: rtl/sample_mixer.sv
// rtl/sample_mixer.sv - voice mixer with handshake output; SAMPLE_MIXER_AVG_EN selects popcount-based shift
module sample_mixer
    import synth_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int ACC_W      = DATA_W + 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  mix_start,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic [DATA_W-1:0]     voice0,
    input  logic [DATA_W-1:0]     voice1,
    input  logic [DATA_W-1:0]     voice2,
    input  logic [DATA_W-1:0]     voice3,
    input  logic [1:0]            gain_shift,
    input  logic                  dac_ready,
    output logic [DATA_W-1:0]     mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic [7:0]            overrun_cnt
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    mix_state_t state, next_state;

    logic [DATA_W-1:0]     voice_in [NUM_VOICES];
    logic [DATA_W-1:0]     voice_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q;
    logic [1:0]            gain_q;
    logic [1:0]            shift_amt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] addend;
    logic [IDX_W-1:0]      idx;
    logic [DATA_W-1:0]     sat_out;
    logic                  capture;
    logic                  overrun;

    assign voice_in[0] = voice0;
    assign voice_in[1] = voice1;
    assign voice_in[2] = voice2;
    assign voice_in[3] = voice3;

`ifdef SAMPLE_MIXER_AVG_EN
    assign shift_amt = avg_shift(en_q);
`else
    assign shift_amt = gain_q;
`endif

    assign addend    = en_q[idx] ? {{(ACC_W-DATA_W){voice_q[idx][DATA_W-1]}}, voice_q[idx]} : '0;
    assign mix_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    sat_shift #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_shift (
        .acc    (acc),
        .shift  (shift_amt),
        .result (sat_out)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state, frame capture and overrun decisions
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        overrun    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mix_start) begin
                    capture    = 1'b1;
                    next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                overrun = mix_start;
                if (idx == LAST_IDX)
                    next_state = ST_SCALE;
            end
            ST_SCALE: begin
                overrun    = mix_start;
                next_state = ST_OUT;
            end
            ST_OUT: begin
                if (dac_ready) begin
                    if (mix_start) begin
                        capture    = 1'b1;
                        next_state = ST_ACCUM;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    overrun = mix_start;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Frame capture, accumulation, output register and overrun counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_VOICES; i++)
                voice_q[i] <= '0;
            en_q        <= '0;
            gain_q      <= '0;
            acc         <= '0;
            idx         <= '0;
            mix_out     <= '0;
            overrun_cnt <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    voice_q[i] <= voice_in[i];
                en_q   <= voice_en;
                gain_q <= gain_shift;
                acc    <= '0;
                idx    <= '0;
            end else if (state == ST_ACCUM) begin
                acc <= acc + addend;
                idx <= idx + 1'b1;
            end
            if (state == ST_SCALE)
                mix_out <= sat_out;
            if (overrun && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: doc/sample_mixer.md
# sample_mixer

Sums the per-voice 16-bit samples loaded by the multinote fetch controller once per sample period, scales and saturates the sum, and presents one mixed sample to the audio DAC stage over a valid/ready handshake. It sits directly downstream of the four voice MDRs. It is triggered by a one-cycle `mix_start` pulse issued after the last MDR load of a sample period.

## Interface
Parameters:
- `DATA_W`, 16: voice and output sample width, two's complement.
- `NUM_VOICES`, 4: number of voice inputs.
- `ACC_W`, `DATA_W+2`: accumulator width, sized for 4 full-scale voices without overflow.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `mix_start` in 1: one-cycle pulse; all voice inputs are valid this cycle.
- `voice_en` in `NUM_VOICES`: per-voice enable mask, sampled with `mix_start`.
- `voice0`..`voice3` in `DATA_W` each: signed samples from MDR1..MDR4.
- `gain_shift` in 2: arithmetic right shift applied to the sum, sampled with `mix_start`.
- `dac_ready` in 1: the DAC stage accepts `mix_out` this cycle.
- `mix_out` out `DATA_W`: mixed, saturated sample.
- `mix_valid` out 1: `mix_out` holds a new sample.
- `busy` out 1: high in every state except IDLE.
- `overrun_cnt` out 8: saturating count of dropped `mix_start` pulses.

## Operation
- FSM states: IDLE, ACCUM, SCALE, OUT.
- **IDLE**
  - On `mix_start`, capture all voices, `voice_en` and `gain_shift` into registers.
  - Clear the accumulator and set the voice index to 0, then go to ACCUM.
- **ACCUM**
  - Each cycle, add the sign-extended captured voice[idx] if en[idx]; otherwise add 0.
  - Increment idx. After idx = `NUM_VOICES`-1, go to SCALE.
- **SCALE**
  - Arithmetic right shift of the accumulator by the shift amount.
  - Saturate to [-32768, 32767], register the result into `mix_out`, then go to OUT.
- **OUT**
  - `mix_valid` = 1.
  - On `dac_ready`, the transfer completes and the FSM goes to IDLE.
  - If `mix_start` is also high in that same cycle, capture the new frame and go directly to ACCUM instead.
- **Overrun:** `mix_start` seen in ACCUM or SCALE, or in OUT without `dac_ready`, is dropped.
  - `overrun_cnt` increments and saturates at 255.
  - The mix in progress is unaffected.
- **Empty mask:** `voice_en` = 0 produces `mix_out` = 0 with normal timing.
- **Output hold:** `mix_out` holds its last value after the handshake until the next SCALE.

## Timing
- Reset values: `mix_out` = 0, `mix_valid` = 0, `busy` = 0, `overrun_cnt` = 0, FSM in IDLE, accumulator = 0.
- Reset mid-operation: the in-flight mix is discarded and no `mix_valid` is produced.
- Cycle numbering, with `mix_start` at cycle 0:
  - Cycles 1–4: ACCUM.
  - Cycle 5: SCALE.
  - Cycle 6 onward: `mix_valid` = 1.
  - Fixed latency: 6 cycles from `mix_start` to `mix_valid`.
- `mix_valid` deasserts the cycle after a `dac_ready` handshake, except in the back-to-back case, where the FSM is in ACCUM.
- Minimum start-to-start interval without overrun: 6 cycles when `dac_ready` is held high.
  - The fetch controller's 16+ cycle sequence always satisfies this.
- `dac_ready` is ignored outside OUT.

## Configuration
- `SAMPLE_MIXER_AVG_EN` defined:
  - `gain_shift` is ignored.
  - The shift amount is derived from the popcount of the captured `voice_en`: 0 or 1 → 0, 2 → 1, 3 or 4 → 2.
  - Result: automatic level normalisation.
- Not defined: the shift amount is the captured `gain_shift`.
- Ports are identical in both builds.

## Structure
- Shared package `synth_pkg`:
  - mixer state enum;
  - `DATA_W` and `NUM_VOICES` defaults;
  - `SAT_MAX`/`SAT_MIN` constants.
- One sub-module, `sat_shift`: combinational arithmetic shift plus saturation from `ACC_W` to `DATA_W`. It is reusable by the later volume stage.

## Test plan
- Voices 1000, 2000, -500, 300; mask 4'b1111; shift 0 → `mix_out` = 2800, `mix_valid` exactly 6 cycles after `mix_start`.
- All voices 32767; mask 4'b1111; shift 0 → `mix_out` = 32767. All voices -32768 → `mix_out` = -32768 (saturation).
- Voices 4000, 4000, 4000, 4000; mask 4'b0011; shift 1 → `mix_out` = 4000. Same stimulus with `SAMPLE_MIXER_AVG_EN` and shift 3 → `mix_out` = 4000.
- `dac_ready` held low 20 cycles while `mix_start` pulses twice → `mix_valid` stays high, `mix_out` unchanged, `overrun_cnt` = 2.
- In OUT, `dac_ready` and `mix_start` high in the same cycle → handshake completes, new frame's `mix_valid` follows 6 cycles after that `mix_start` (cycle count as in the first scenario), `overrun_cnt` unchanged.
- `Reset` asserted in cycle 3 of ACCUM → all outputs 0 the next cycle; no `mix_valid` afterwards until a new `mix_start`.
